// File: rtl/int_to_float_seq.sv
// Signed 32-bit integer to IEEE-754 single, one conversion in flight; latency k+2 (k = leading zeros), 1 for zero.
// Result held in DONE until out_ready; in_ready only in IDLE. Define ROUND_NEAREST_EN for ties-to-even, else truncate.
module int_to_float_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_inexact
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sign;
    logic [31:0] mag;
    logic [4:0]  cnt;

    logic [31:0] in_mag;
    logic        accept;
    logic [7:0]  exp_base;
    logic [7:0]  exp_fin;
    logic [22:0] mant_t;
    logic [23:0] mant_sum;
    logic        guard;
    logic        sticky;
    logic        rnd_inc;

    // -2^31 negates to itself, which is exactly the required unsigned magnitude
    assign in_mag = in_data[31] ? (~in_data + 32'd1) : in_data;
    assign accept = in_valid & in_ready;

    assign exp_base = 8'd158 - {3'b000, cnt};
    assign mant_t   = mag[30:8];
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
`ifdef ROUND_NEAREST_EN
    assign rnd_inc  = guard & (sticky | mant_t[0]);
`else
    assign rnd_inc  = 1'b0;
`endif
    // a mantissa carry-out leaves mant_sum[22:0] at zero and bumps the exponent
    assign mant_sum = {1'b0, mant_t} + {23'd0, rnd_inc};
    assign exp_fin  = exp_base + {7'd0, mant_sum[23]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (in_mag == 32'd0) ? DONE : NORM;
            NORM:    if (mag[31]) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign        <= 1'b0;
            mag         <= 32'd0;
            cnt         <= 5'd0;
            out_float   <= 32'd0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign        <= in_data[31];
                        mag         <= in_mag;
                        cnt         <= 5'd0;
                        out_float   <= 32'd0;
                        out_inexact <= 1'b0;
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag <= {mag[30:0], 1'b0};
                        cnt <= cnt + 5'd1;
                    end
                end
                ROUND: begin
                    out_float   <= {sign, exp_fin, mant_sum[22:0]};
                    out_inexact <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed vector table plus backpressure and mid-conversion reset sequences for int_to_float_seq.
module tb_int_to_float_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;

    int passed = 0;
    int total  = 0;

    int_to_float_seq dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_float   (out_float),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] fexp;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Accept d, wait for the result, then complete the output handshake.
    // lat counts clock edges after the accept edge until out_valid is seen.
    task automatic do_conv(input logic [31:0] d, output logic [31:0] f, output logic inx,
                           output int lat, output logic busy_rdy, output logic rdy_after);
        int g;
        g = 0;
        busy_rdy = 1'b0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            busy_rdy = busy_rdy | in_ready;
            @(posedge clk); #1;
            lat++;
        end
        busy_rdy = busy_rdy | in_ready;
        f   = out_float;
        inx = out_inexact;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy_after = in_ready;
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] f0;
        logic        inx;
        logic        busy_rdy;
        logic        rdy_after;
        logic        unstable;
        logic        seen_valid;
        int          lat;

        vecs[0]  = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 33};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33};
        vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1};
        vecs[3]  = '{32'h8000_0000, 32'hCF00_0000, 1'b0, 2};
`ifdef ROUND_NEAREST_EN
        vecs[4]  = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3};
        vecs[5]  = '{32'h0100_0003, 32'h4B80_0002, 1'b1, 9};
        vecs[10] = '{32'hFEFF_FFFD, 32'hCB80_0002, 1'b1, 9};
`else
        vecs[4]  = '{32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1, 3};
        vecs[5]  = '{32'h0100_0003, 32'h4B80_0001, 1'b1, 9};
        vecs[10] = '{32'hFEFF_FFFD, 32'hCB80_0001, 1'b1, 9};
`endif
        vecs[6]  = '{32'h0100_0001, 32'h4B80_0000, 1'b1, 9};
        vecs[7]  = '{32'h0000_0064, 32'h42C8_0000, 1'b0, 27};
        vecs[8]  = '{32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 31};
        vecs[9]  = '{32'h0100_0005, 32'h4B80_0002, 1'b1, 9};
        vecs[11] = '{32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0, 10};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rdy_in_reset", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_float", out_float, 32'd0);
        chk("rst_out_inexact", {31'd0, out_inexact}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rdy_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_conv(vecs[i].din, f, inx, lat, busy_rdy, rdy_after);
            chk($sformatf("float[%0d]", i), f, vecs[i].fexp);
            chk($sformatf("inexact[%0d]", i), {31'd0, inx}, {31'd0, vecs[i].inx});
            // a zero input is registered straight into DONE on the accept edge
            if (vecs[i].din == 32'd0) chk($sformatf("lat[%0d]", i), {31'd0, lat <= 1}, 32'd1);
            else chk($sformatf("lat[%0d]", i), lat, vecs[i].lat);
            chk($sformatf("busy_rdy[%0d]", i), {31'd0, busy_rdy}, 32'd0);
            chk($sformatf("rdy_after[%0d]", i), {31'd0, rdy_after}, 32'd1);
        end

        // Backpressure: result must hold while out_ready stays low.
        in_valid = 1'b1;
        in_data  = 32'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", lat, 27);
        f0 = out_float;
        unstable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            unstable = unstable | (out_float !== f0) | !out_valid | in_ready;
        end
        chk("bp_float", f0, 32'h42C8_0000);
        chk("bp_stable", {31'd0, unstable}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("bp_rdy_idle", {31'd0, in_ready}, 32'd1);

        // Reset mid-NORM discards the conversion.
        in_valid = 1'b1;
        in_data  = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rdy_low_reset", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_float", out_float, 32'd0);
        chk("mid_rst_inexact", {31'd0, out_inexact}, 32'd0);
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        chk("mid_rst_no_out", {31'd0, seen_valid}, 32'd0);
        do_conv(32'd100, f, inx, lat, busy_rdy, rdy_after);
        chk("post_rst_float", f, 32'h42C8_0000);
        chk("post_rst_lat", lat, 27);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
